bin_frame_feeder: RTL
=====================

BIN_FRAME_FEEDER -- requirements
Module: bin_frame_feeder

Interface
REQ-001 SHALL have parameter N, default 16: bin magnitude width in bits.
REQ-002 SHALL have parameter BPO, default 24: bins per octave.
REQ-003 SHALL have parameter OCT, default 5: octaves; BINS = BPO*OCT (120).
REQ-004 SHALL have parameter TIMEOUT, default 1023: maximum cycles spent waiting for finished.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 binData  input  N  magnitude of one DFT bin.
REQ-009 binIndex  input  7  bin number, 0..BINS-1.
REQ-010 binValid  input  1  binData/binIndex/binLast valid.
REQ-011 binLast  input  1  this bin completes the frame.
REQ-012 binReady  output  1  feeder accepts a bin this cycle.
REQ-013 finished  input  1  one-cycle completion pulse from the note finder.
REQ-014 dftBins  output  [0:BINS-1][N-1:0]  presented frame, unsigned.
REQ-015 startCycle  output  1  one-cycle pulse that launches the note finder.
REQ-016 busy  output  1  high in START or WAIT.
REQ-017 frameCount  output  16  frames launched, wrapping modulo 2^16.
REQ-018 errIndex  output  1  sticky flag: an out-of-range index was accepted.
REQ-019 errTimeout  output  1  sticky flag: a WAIT timeout occurred.

Function
REQ-020 SHALL hold two banks of BINS registers: a fill bank and a present bank; dftBins SHALL always drive the present bank.
REQ-021 A bin SHALL be accepted on any edge where binValid && binReady; binData is written to fill[binIndex], and the last write to an index wins.
REQ-022 An accepted bin with binIndex >= BINS SHALL discard its data and set errIndex; if it carries binLast, it SHALL still complete the frame.
REQ-023 The FSM SHALL have three states: IDLE, START and WAIT; startCycle SHALL equal (state==START), registered.
REQ-024 Define frameDone = pending || (accepted && binLast); define free = (state==IDLE) || (state==WAIT && (finished || timer==TIMEOUT)).
REQ-025 On an edge with frameDone && free, the block SHALL swap bank roles, clear the new fill bank to 0, clear pending, increment frameCount, and go to START.
REQ-026 On an edge with frameDone && !free, it SHALL set pending; binReady SHALL be !pending.
REQ-027 On an edge with free && !frameDone, the state SHALL go to IDLE.
REQ-028 START SHALL last exactly one cycle, then go to WAIT with timer cleared to 0.
REQ-029 The WAIT timer SHALL increment every cycle; reaching TIMEOUT without finished SHALL set errTimeout and be treated as finished.
REQ-030 finished outside WAIT SHALL be ignored.
REQ-031 dftBins SHALL remain unchanged from the startCycle cycle until the next swap.
REQ-032 Bins not written during a frame SHALL present as 0.
REQ-033 Latency: when the last bin is accepted at edge k in IDLE, startCycle SHALL be high in the cycle after edge k, with its data included in dftBins.

Reset
REQ-034 While rst is high, the block SHALL force: both banks 0, state IDLE, startCycle 0, binReady 1, pending 0, timer 0, frameCount 0, errIndex 0, errTimeout 0, busy 0.
REQ-035 Reset asserted mid-frame or mid-WAIT SHALL discard the partial frame and the pending frame; the first frame after reset SHALL start cleanly.

Verification
REQ-036 Fill bins 0..119 with value 16'h0100+i, binLast on bin 119, in IDLE -> startCycle pulses one cycle later; dftBins[i]=16'h0100+i; frameCount=1; busy=1.
REQ-037 Complete a second frame during WAIT -> binReady=0 until finished; finished pulse -> startCycle on the next cycle; dftBins stays on frame 1 until the swap.
REQ-038 finished and binLast on the same edge in WAIT -> swap on that edge; startCycle next cycle; pending is never set.
REQ-039 Never pulse finished -> after TIMEOUT cycles in WAIT, state=IDLE and errTimeout=1; the next complete frame still launches.
REQ-040 Frame writing only bin 5=16'hABCD plus binIndex=120 with binLast -> dftBins[5]=16'hABCD, all other bins 0, errIndex=1.
REQ-041 Assert rst mid-WAIT with a frame pending -> all outputs at reset values; a new single frame yields frameCount=1.

Source files
------------

// File: rtl/bin_frame_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : bin_frame_feeder
//  Description : Double-buffered DFT bin collector. Bins are written into a
//                fill bank by index. A completed frame is swapped into the
//                present bank and the note finder is launched with a
//                one-cycle startCycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_frame_feeder #(
    parameter int N       = 16,
    parameter int BPO     = 24,
    parameter int OCT     = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   binData,
    input  logic [6:0]                     binIndex,
    input  logic                           binValid,
    input  logic                           binLast,
    output logic                           binReady,
    input  logic                           finished,
    output logic [0:BPO*OCT-1][N-1:0]      dftBins,
    output logic                           startCycle,
    output logic                           busy,
    output logic [15:0]                    frameCount,
    output logic                           errIndex,
    output logic                           errTimeout
);

    localparam int BINS = BPO * OCT;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef logic [0:BINS-1][N-1:0] bank_t;

    state_t          r_state;
    state_t          w_stateNext;
    bank_t           r_fill;
    bank_t           r_present;
    bank_t           w_fillNext;
    logic            r_pending;
    logic [TW-1:0]   r_timer;
    logic [15:0]     r_frameCount;
    logic            r_errIndex;
    logic            r_errTimeout;

    logic            w_accepted;
    logic            w_inRange;
    logic            w_frameDone;
    logic            w_timeout;
    logic            w_free;
    logic            w_swap;

    // Handshake and frame-completion qualifiers; a timeout counts as finished
    always_comb begin
        w_accepted  = binValid && !r_pending;
        w_inRange   = (32'(binIndex) < 32'(BINS));
        w_frameDone = r_pending || (w_accepted && binLast);
        w_timeout   = (r_state == WAIT) && (r_timer == TW'(TIMEOUT));
        w_free      = (r_state == IDLE) ||
                      ((r_state == WAIT) && (finished || w_timeout));
        w_swap      = w_frameDone && w_free;
    end

    // Fill bank contents including this cycle's accepted in-range bin
    always_comb begin
        w_fillNext = r_fill;
        if (w_accepted && w_inRange) begin
            w_fillNext[binIndex] = binData;
        end
    end

    // Next-state logic: swap launches START, an idle-able state with no frame drops to IDLE
    always_comb begin
        w_stateNext = r_state;
        if (w_swap) begin
            w_stateNext = START;
        end else if (w_free) begin
            w_stateNext = IDLE;
        end else if (r_state == START) begin
            w_stateNext = WAIT;
        end else if (r_state == WAIT) begin
            w_stateNext = WAIT;
        end else begin
            w_stateNext = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Bank storage: on swap the completed fill becomes the presented frame and fill restarts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill    <= '0;
            r_present <= '0;
        end else if (w_swap) begin
            r_present <= w_fillNext;
            r_fill    <= '0;
        end else begin
            r_fill    <= w_fillNext;
        end
    end

    // Control registers: pending frame, WAIT timer, launch counter and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_timer      <= '0;
            r_frameCount <= '0;
            r_errIndex   <= 1'b0;
            r_errTimeout <= 1'b0;
        end else begin
            r_pending <= w_frameDone && !w_free;
            if (r_state == WAIT) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
            if (w_swap) begin
                r_frameCount <= r_frameCount + 16'd1;
            end
            if (w_accepted && !w_inRange) begin
                r_errIndex <= 1'b1;
            end
            if (w_timeout && !finished) begin
                r_errTimeout <= 1'b1;
            end
        end
    end

    assign binReady   = !r_pending;
    assign dftBins    = r_present;
    assign startCycle = (r_state == START);
    assign busy       = (r_state == START) || (r_state == WAIT);
    assign frameCount = r_frameCount;
    assign errIndex   = r_errIndex;
    assign errTimeout = r_errTimeout;

endmodule
`default_nettype wire
